// File: rtl/bin_to_bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock; optional leading-zero
// flags under `BIN_TO_BCD_ITER_BLANK_EN. Latency BIN_W+2 edges from accepted start to valid_o.
// No backpressure: start_i is accepted only in IDLE, ignored while busy_o is high.
module bin_to_bcd_iter #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [ACC_W-1:0] SAT_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   op_q, op_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovfo_q, ovfo_d;
    logic               valid_q, valid_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic               shift_out;

    // Add-3 correction is per 4-bit digit; carries are deliberately discarded.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shift_out = acc_adj[ACC_W-1];
    assign acc_shift = {acc_adj[ACC_W-2:0], op_q[BIN_W-1]};

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? CONVERT : IDLE;
            CONVERT: state_d = (cnt_q == LAST_ITER) ? DONE : CONVERT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o = (state_q == CONVERT) || (state_q == DONE);
    end

    always_comb begin
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d  = bin_i;
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            CONVERT: begin
                acc_d = acc_shift;
                op_d  = op_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_q | shift_out;
            end
            DONE: begin
                bcd_d   = ovf_q ? SAT_NINES : acc_q;
                ovfo_d  = ovf_q;
                valid_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
            valid_q <= valid_d;
        end
    end

    assign bcd_o      = bcd_q;
    assign overflow_o = ovfo_q;
    assign valid_o    = valid_q;

`ifdef BIN_TO_BCD_ITER_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_calc;
    logic              upper_zero;

    // Digit i is blank when it and every digit above it are zero; ones digit never blanks.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (acc_q[4*i +: 4] == 4'd0);
            blank_calc[i] = upper_zero & ~ovf_q;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == DONE) begin
            blank_d = blank_calc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_iter.sv
// Bench for bin_to_bcd_iter: four parameterisations checked against an arithmetic BCD model.
module tb_bin_to_bcd_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] start = 4'b0;
    logic [6:0]  bin0 = '0;
    logic [6:0]  bin1 = '0;
    logic [15:0] bin2 = '0;
    logic [0:0]  bin3 = '0;

    logic        busy0, busy1, busy2, busy3;
    logic        valid0, valid1, valid2, valid3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic [3:0]  bcd3;
    logic [2:0]  blank0;
    logic [1:0]  blank1;
    logic [4:0]  blank2;
    logic [0:0]  blank3;

    int checks = 0;
    int errors = 0;
    int BW [4] = '{7, 7, 16, 1};
    int DG [4] = '{3, 2, 5, 1};

    logic        busy_w  [4];
    logic        valid_w [4];
    logic        ovf_w   [4];
    logic [39:0] bcd_w   [4];
    logic [9:0]  blank_w [4];

    always #5 clk = ~clk;

    bin_to_bcd_iter #(.BIN_W(7), .DIGITS(3)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .bin_i(bin0), .busy_o(busy0),
        .valid_o(valid0), .bcd_o(bcd0), .overflow_o(ovf0), .blank_o(blank0));
    bin_to_bcd_iter #(.BIN_W(7), .DIGITS(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .bin_i(bin1), .busy_o(busy1),
        .valid_o(valid1), .bcd_o(bcd1), .overflow_o(ovf1), .blank_o(blank1));
    bin_to_bcd_iter #(.BIN_W(16), .DIGITS(5)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .bin_i(bin2), .busy_o(busy2),
        .valid_o(valid2), .bcd_o(bcd2), .overflow_o(ovf2), .blank_o(blank2));
    bin_to_bcd_iter #(.BIN_W(1), .DIGITS(1)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .bin_i(bin3), .busy_o(busy3),
        .valid_o(valid3), .bcd_o(bcd3), .overflow_o(ovf3), .blank_o(blank3));

    always_comb begin
        busy_w[0] = busy0;   busy_w[1] = busy1;   busy_w[2] = busy2;   busy_w[3] = busy3;
        valid_w[0] = valid0; valid_w[1] = valid1; valid_w[2] = valid2; valid_w[3] = valid3;
        ovf_w[0] = ovf0;     ovf_w[1] = ovf1;     ovf_w[2] = ovf2;     ovf_w[3] = ovf3;
        bcd_w[0] = 40'(bcd0); bcd_w[1] = 40'(bcd1); bcd_w[2] = 40'(bcd2); bcd_w[3] = 40'(bcd3);
        blank_w[0] = 10'(blank0); blank_w[1] = 10'(blank1);
        blank_w[2] = 10'(blank2); blank_w[3] = 10'(blank3);
    end

    // Reference: decimal digits by division; overflow when value needs more than DIGITS digits.
    function automatic void model(input int idx, input longint unsigned v,
                                  output logic [39:0] e_bcd, output logic e_ovf,
                                  output logic [9:0] e_blank);
        longint unsigned lim = 1;
        longint unsigned t;
        longint unsigned pw;
        for (int i = 0; i < DG[idx]; i++) lim = lim * 10;
        e_bcd = '0;
        e_blank = '0;
        e_ovf = (v >= lim);
        t = v;
        for (int i = 0; i < DG[idx]; i++) begin
            e_bcd[4*i +: 4] = e_ovf ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
`ifdef BIN_TO_BCD_ITER_BLANK_EN
        pw = 1;
        for (int i = 1; i < DG[idx]; i++) begin
            pw = pw * 10;
            e_blank[i] = !e_ovf && (v < pw);
        end
`else
        pw = 0;
`endif
    endfunction

    task automatic set_bin(input int idx, input longint unsigned v);
        case (idx)
            0: bin0 = 7'(v);
            1: bin1 = 7'(v);
            2: bin2 = 16'(v);
            default: bin3 = 1'(v);
        endcase
    endtask

    // Launch one conversion and check latency, busy length, result, pulse width and hold.
    task automatic conv_check(input int idx, input longint unsigned v);
        int k;
        int busy_n;
        bit seen;
        logic [39:0] e_bcd;
        logic e_ovf;
        logic [9:0] e_blank;
        model(idx, v, e_bcd, e_ovf, e_blank);
        @(negedge clk);
        set_bin(idx, v);
        start[idx] = 1'b1;
        @(posedge clk); #1;
        start[idx] = 1'b0;
        busy_n = 0;
        seen = 0;
        k = 0;
        while (k < 80) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (valid_w[idx]) begin
                seen = 1;
                break;
            end
            if (busy_w[idx]) busy_n++;
            k++;
        end
        checks++;
        if (!seen || k != BW[idx] + 1) begin
            errors++;
            $display("FAIL latency dut%0d v=%0d got %0d (seen=%0d) exp %0d", idx, v, k, seen, BW[idx] + 1);
        end
        checks++;
        if (busy_n != BW[idx] + 1) begin
            errors++;
            $display("FAIL busy_len dut%0d v=%0d got %0d exp %0d", idx, v, busy_n, BW[idx] + 1);
        end
        checks++;
        if (bcd_w[idx] !== e_bcd || ovf_w[idx] !== e_ovf || blank_w[idx] !== e_blank) begin
            errors++;
            $display("FAIL result dut%0d v=%0d got bcd=%h ovf=%b blank=%b exp bcd=%h ovf=%b blank=%b",
                     idx, v, bcd_w[idx], ovf_w[idx], blank_w[idx], e_bcd, e_ovf, e_blank);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_w[idx] !== 1'b0 || bcd_w[idx] !== e_bcd || ovf_w[idx] !== e_ovf) begin
            errors++;
            $display("FAIL pulse_hold dut%0d got valid=%b bcd=%h exp valid=0 bcd=%h",
                     idx, valid_w[idx], bcd_w[idx], e_bcd);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0 || ovf_w[i] !== 1'b0 ||
                bcd_w[i] !== 40'd0 || blank_w[i] !== 10'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got busy=%b valid=%b ovf=%b bcd=%h blank=%b exp all zero",
                         i, busy_w[i], valid_w[i], ovf_w[i], bcd_w[i], blank_w[i]);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        conv_check(0, 127);
        conv_check(0, 0);
        conv_check(0, 100);
        conv_check(1, 100);
        conv_check(1, 99);
        conv_check(1, 10);
        conv_check(2, 65535);
        conv_check(2, 5);
        conv_check(2, 0);
        conv_check(3, 0);
        conv_check(3, 1);
    endtask

    task automatic test_random();
        int idx;
        longint unsigned v;
        for (int n = 0; n < 24; n++) begin
            idx = $urandom_range(0, 3);
            case (idx)
                0, 1: v = $urandom_range(0, 127);
                2: v = $urandom_range(0, 65535);
                default: v = $urandom_range(0, 1);
            endcase
            conv_check(idx, v);
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        @(negedge clk);
        bin0 = 7'd42;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bin0 = 7'd7;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (valid_w[0]) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (bcd_w[0] !== 40'h042 || ovf_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result got bcd=%h ovf=%b exp bcd=042 ovf=0", bcd_w[0], ovf_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int first_k = -1;
        int second_k = -1;
        longint unsigned a, b;
        logic [39:0] ea, eb;
        logic eo;
        logic [9:0] el;
        a = $urandom_range(0, 127);
        b = $urandom_range(0, 127);
        model(0, a, ea, eo, el);
        model(0, b, eb, eo, el);
        @(negedge clk);
        bin0 = 7'(a);
        start[0] = 1'b1;
        @(posedge clk); #1;
        while (k < 60 && second_k < 0) begin
            @(posedge clk); #1;
            k++;
            if (k == first_k + 1 && first_k >= 0) start[0] = 1'b0;
            if (valid_w[0]) begin
                if (first_k < 0) begin
                    first_k = k;
                    checks++;
                    if (bcd_w[0] !== ea) begin
                        errors++;
                        $display("FAIL b2b_first got %h exp %h", bcd_w[0], ea);
                    end
                    bin0 = 7'(b);
                end else begin
                    second_k = k;
                end
            end
        end
        start[0] = 1'b0;
        checks++;
        if (first_k != 8 || second_k != 17) begin
            errors++;
            $display("FAIL b2b_timing got %0d/%0d exp 8/17", first_k, second_k);
        end
        checks++;
        if (bcd_w[0] !== eb) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", bcd_w[0], eb);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        bin0 = 7'd85;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || bcd_w[0] !== 40'd0 ||
            ovf_w[0] !== 1'b0 || blank_w[0] !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_clear got busy=%b valid=%b bcd=%h ovf=%b blank=%b exp all zero",
                     busy_w[0], valid_w[0], bcd_w[0], ovf_w[0], blank_w[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (valid_w[0] || busy_w[0]) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_abort got %0d active cycles exp 0", pulses);
        end
        conv_check(0, 85);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
